// File: rtl/ltile_clb_fle_array_if.sv
// Fabric/config bus of the CLB tile: config shift chain, scan chain and user fabric pins.
// Optional fabric_clr pin exists only when CLB_FLE_SYNC_CLR_EN is defined.
interface ltile_clb_fle_array_if #(
  parameter int NUM_FLE = 4,
  parameter int LUT_K   = 4
);
  logic                       ccff_en;
  logic                       ccff_head;
  logic                       ccff_tail;
  logic                       cfg_done;
  logic                       Test_en;
  logic [NUM_FLE*LUT_K-1:0]   fabric_in;
  logic                       fabric_regin;
  logic                       fabric_sc_in;
  logic [NUM_FLE-1:0]         fabric_out;
  logic                       fabric_regout;
  logic                       fabric_sc_out;
`ifdef CLB_FLE_SYNC_CLR_EN
  logic                       fabric_clr;
`endif

  modport master (
    output ccff_en, ccff_head, Test_en, fabric_in, fabric_regin, fabric_sc_in,
`ifdef CLB_FLE_SYNC_CLR_EN
    output fabric_clr,
`endif
    input  ccff_tail, cfg_done, fabric_out, fabric_regout, fabric_sc_out
  );

  modport slave (
    input  ccff_en, ccff_head, Test_en, fabric_in, fabric_regin, fabric_sc_in,
`ifdef CLB_FLE_SYNC_CLR_EN
    input  fabric_clr,
`endif
    output ccff_tail, cfg_done, fabric_out, fabric_regout, fabric_sc_out
  );
endinterface

// File: rtl/ltile_clb_fle_array.sv
// Parametrised CLB tile: NUM_FLE LUT+FF elements configured from one serial chain.
// Optional per-element synchronous clear enabled by defining CLB_FLE_SYNC_CLR_EN.
module ltile_clb_fle_array #(
  parameter int NUM_FLE = 4,
  parameter int LUT_K   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ltile_clb_fle_array_if.slave bus
);
  localparam int TT_BITS = 1 << LUT_K;
`ifdef CLB_FLE_SYNC_CLR_EN
  localparam int CFG_PER_FLE = TT_BITS + 3;
`else
  localparam int CFG_PER_FLE = TT_BITS + 2;
`endif
  localparam int CFG_BITS = NUM_FLE * CFG_PER_FLE;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

  logic [CFG_BITS-1:0] cfg_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    cnt_next;
  logic                cfg_done_reg;
  logic [NUM_FLE-1:0]  q_reg;
  logic [NUM_FLE-1:0]  q_next;
  logic [NUM_FLE-1:0]  lut_out;

  // Count saturates so extra shifts pass data downstream without disturbing cfg_done.
  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_reg != CNT_MAX)
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_reg      <= '0;
      cnt_reg      <= '0;
      cfg_done_reg <= 1'b0;
    end else if (bus.ccff_en) begin
      cfg_reg      <= {cfg_reg[CFG_BITS-2:0], bus.ccff_head};
      cnt_reg      <= cnt_next;
      cfg_done_reg <= (cnt_next == CNT_MAX);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLE; gi++) begin : g_fle
      logic [TT_BITS-1:0] truth;
      logic [LUT_K-1:0]   lut_sel;
      logic               dsel;
      logic               osel;
      logic               prev_q;
      logic               scan_src;
      logic               chain_src;

      assign truth   = cfg_reg[gi*CFG_PER_FLE +: TT_BITS];
      assign dsel    = cfg_reg[gi*CFG_PER_FLE + TT_BITS];
      assign osel    = cfg_reg[gi*CFG_PER_FLE + TT_BITS + 1];
      assign lut_sel = bus.fabric_in[gi*LUT_K +: LUT_K];
      assign lut_out[gi] = truth[lut_sel];

      if (gi == 0) begin : g_head
        assign prev_q    = 1'b0;
        assign scan_src  = bus.fabric_sc_in;
        assign chain_src = bus.fabric_regin;
      end else begin : g_link
        assign prev_q    = q_reg[gi-1];
        assign scan_src  = prev_q;
        assign chain_src = prev_q;
      end

`ifdef CLB_FLE_SYNC_CLR_EN
      logic clr_en;
      assign clr_en = cfg_reg[gi*CFG_PER_FLE + TT_BITS + 2];
      always_comb begin
        q_next[gi] = q_reg[gi];
        if (bus.ccff_en)
          q_next[gi] = q_reg[gi];
        else if (bus.Test_en)
          q_next[gi] = scan_src;
        else if (clr_en && bus.fabric_clr)
          q_next[gi] = 1'b0;
        else
          q_next[gi] = dsel ? chain_src : lut_out[gi];
      end
`else
      always_comb begin
        q_next[gi] = q_reg[gi];
        if (bus.ccff_en)
          q_next[gi] = q_reg[gi];
        else if (bus.Test_en)
          q_next[gi] = scan_src;
        else
          q_next[gi] = dsel ? chain_src : lut_out[gi];
      end
`endif

      assign bus.fabric_out[gi] = osel ? q_reg[gi] : lut_out[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      q_reg <= '0;
    else
      q_reg <= q_next;
  end

  assign bus.ccff_tail     = cfg_reg[CFG_BITS-1];
  assign bus.cfg_done      = cfg_done_reg;
  assign bus.fabric_regout = q_reg[NUM_FLE-1];
  assign bus.fabric_sc_out = q_reg[NUM_FLE-1];
endmodule
